// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer.
// Data width and sequencer state encoding.
package uart_tx_buffer_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } tx_state_e;

  typedef logic [UART_DATA_W-1:0] tx_byte_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO: DEPTH x 8 storage with occupancy counter.
// Full/empty come from the counter; pointers wrap freely.
module uart_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_push,
  input  tx_byte_t          i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output tx_byte_t          o_head,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  tx_byte_t          mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);
  assign o_count = count_q;
  assign o_head  = mem_q[rdPtr_q];

  // Flush overrides both directions; a full FIFO never takes a write.
  assign push_ok = i_push && !o_full  && !i_flush;
  assign pop_ok  = i_pop  && !o_empty && !i_flush;

  // Next pointers and occupancy.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_ok) wrPtr_d = wrPtr_q + 1'b1;
      if (pop_ok)  rdPtr_d = rdPtr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wrPtr_q] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus launch sequencer feeding uart_tx.
// One enable pulse per byte, next launch waits for doneTx.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstN,
  input  logic                   i_wrValid,
  input  logic [UART_DATA_W-1:0] i_wrData,
  output logic                   o_wrReady,
  input  logic                   i_flush,
  output logic                   o_enableTx,
  output logic [UART_DATA_W-1:0] o_bitsTx,
  input  logic                   i_doneTx,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_busy
);

  tx_state_e state_q, state_d;
  tx_byte_t  bits_q, bits_d;
  logic      enable_q, enable_d;
  tx_byte_t  head;
  logic      fifo_empty;
  logic      fifo_full;
  logic      launch;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstN  (i_rstN),
    .i_push  (i_wrValid),
    .i_data  (i_wrData),
    .i_pop   (launch),
    .i_flush (i_flush),
    .o_head  (head),
    .o_count (o_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_empty    = fifo_empty;
  assign o_full     = fifo_full;
  assign o_wrReady  = !fifo_full;
  assign o_enableTx = enable_q;
  assign o_bitsTx   = bits_q;
  assign o_busy     = (state_q != ST_IDLE);

  // A flush in the same cycle suppresses the launch.
  assign launch = (state_q == ST_IDLE) && !fifo_empty && !i_flush;

  // Sequencer next state, launch byte and enable pulse.
  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    enable_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = ST_LAUNCH;
          bits_d   = head;
          enable_d = 1'b1;
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        if (i_doneTx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      state_q  <= ST_IDLE;
      bits_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      enable_q <= enable_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Random stimulus bench for uart_tx_buffer.
// Queue-based reference model, uart_tx emulated by delayed done.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rstN;
  logic       wrValid;
  logic [7:0] wrData;
  logic       wrReady;
  logic       flush;
  logic       enableTx;
  logic [7:0] bitsTx;
  logic       doneTx;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       busy;

  uart_tx_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (4)
  ) dut (
    .i_clk      (clk),
    .i_rstN     (rstN),
    .i_wrValid  (wrValid),
    .i_wrData   (wrData),
    .o_wrReady  (wrReady),
    .i_flush    (flush),
    .o_enableTx (enableTx),
    .o_bitsTx   (bitsTx),
    .i_doneTx   (doneTx),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  tag, got, exp, $time);
  endtask

  // Reference model: stored bytes, in-flight phase, last launched byte.
  // phase 0 = nothing in flight, 1 = launch cycle, 2 = awaiting done.
  logic [7:0] m_q [$];
  int         m_phase;
  logic [7:0] m_bits;
  int         tx_left;
  int         sent;

  function automatic void model_reset();
    m_q.delete();
    m_phase = 0;
    m_bits  = 8'h00;
  endfunction

  function automatic void model_step();
    bit acc;
    bit pop;
    int nph;
    acc = wrValid && (m_q.size() < DEPTH) && !flush;
    pop = (m_phase == 0) && (m_q.size() > 0) && !flush;
    nph = m_phase;
    if (pop) begin
      m_bits = m_q.pop_front();
      nph = 1;
      sent++;
    end else if (m_phase == 1) nph = 2;
    else if (m_phase == 2 && doneTx) nph = 0;
    if (flush) m_q.delete();
    else if (acc) m_q.push_back(wrData);
    m_phase = nph;
  endfunction

  task automatic check_all();
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("wrReady", 32'(wrReady), 32'(m_q.size() != DEPTH));
    check("enableTx", 32'(enableTx), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("bitsTx", 32'(bitsTx), 32'(m_bits));
  endtask

  task automatic check_reset_vals();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_enable", 32'(enableTx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bits", 32'(bitsTx), 32'd0);
  endtask

  // Drive one cycle of inputs; uart_tx finishes 2..12 cycles after launch.
  task automatic drive(input int wr_pct, input int fl_pml, input int st_pml);
    wrValid = ($urandom_range(99) < wr_pct);
    wrData  = 8'($urandom);
    flush   = ($urandom_range(999) < fl_pml);
    doneTx  = 1'b0;
    if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) doneTx = 1'b1;
    end else if ($urandom_range(999) < st_pml) doneTx = 1'b1;
  endtask

  task automatic run(input int cycles, input int wr_pct,
                     input int fl_pml, input int st_pml);
    repeat (cycles) begin
      @(negedge clk);
      drive(wr_pct, fl_pml, st_pml);
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (enableTx) tx_left = $urandom_range(12, 2);
    end
  endtask

  // Reset asserted mid-cycle; uart_tx keeps counting and may send a late done.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #10 rstN = 1'b0;
    #1 check_reset_vals();
    model_reset();
    repeat (hold) begin
      @(negedge clk);
      drive(60, 0, 20);
      @(posedge clk);
      #1 check_reset_vals();
    end
    @(negedge clk);
    wrValid = 1'b0;
    flush   = 1'b0;
    doneTx  = 1'b0;
    rstN    = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    sent    = 0;
    tx_left = 0;
    rstN    = 1'b0;
    wrValid = 1'b0;
    wrData  = 8'h00;
    flush   = 1'b0;
    doneTx  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk);
    rstN = 1'b1;

    run(20, 5, 0, 0);
    run(600, 90, 0, 0);
    run(400, 8, 0, 0);
    run(800, 50, 6, 8);
    run(15, 80, 0, 0);
    do_reset(3);
    run(600, 70, 12, 12);
    run(10, 90, 0, 0);
    do_reset(2);
    run(400, 30, 0, 4);
    run(300, 100, 3, 0);

    check("bytes_sent_nonzero", 32'(sent > 100), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
